poly_key_tone_player: RTL

- Parametrised keyboard-to-tone engine. Maps NUM_KEYS debounced key levels to one square-wave note on the buzzer pin.
- Adds the following over the fixed switch-to-tone test:
  - note-priority modes (last-pressed or lowest-index)
  - white-key or chromatic key mapping
  - global octave shift
  - a timed release tail after all keys go up
  - mute
- Sits between the switch/button edge logic and the buzzer pin, and replaces the separate frequency register plus player.

---
 rtl/poly_key_tone_player_pkg.sv | 38 +++
 rtl/poly_key_tone_player_if.sv | 24 ++
 rtl/poly_key_tone_player_tone_divider.sv | 36 +++
 rtl/poly_key_tone_player.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/poly_key_tone_player_pkg.sv
// Shared tone tables, engine state type and elaboration-time pitch helpers.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package tone_pkg;

  // Octave-4 note frequencies in Hz, C4 in the low slice up to B4 in the high slice.
  localparam logic [12*12-1:0] FREQ_TAB = {
    12'd494, 12'd466, 12'd440, 12'd415, 12'd392, 12'd370,
    12'd349, 12'd330, 12'd311, 12'd294, 12'd277, 12'd262
  };

  // Semitone offsets of the white keys C D E F G A B, C in the low slice.
  localparam logic [7*4-1:0] WHITE_OFS = {
    4'd11, 4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic int freq_hz(input int n);
    return int'(FREQ_TAB[(n % 12) * 12 +: 12]);
  endfunction

  // Key index to semitone above C4, for white-key or chromatic layouts.
  function automatic int semitone_of(input int k, input int chromatic);
    if (chromatic != 0) return k;
    return 12 * (k / 7) + int'(WHITE_OFS[(k % 7) * 4 +: 4]);
  endfunction

  // Half-period in clock cycles of the octave-4 note sharing this pitch class.
  function automatic int base_half(input int clk_hz, input int s);
    return clk_hz / (2 * freq_hz(s));
  endfunction

endpackage

// File: rtl/poly_key_tone_player_if.sv
// Key/control inputs and tone outputs of the key-to-tone engine.
// Latency: n/a (signal bundle).
// Backpressure: none; master drives key/oct_shift/mute, slave drives buzzer/note_valid/note_idx.
interface poly_key_tone_player_if #(
  parameter int NUM_KEYS = 12,
  parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
);
  logic [NUM_KEYS-1:0] key;
  logic [1:0]          oct_shift;
  logic                mute;
  logic                buzzer;
  logic                note_valid;
  logic [IDX_W-1:0]    note_idx;

  modport master (
    output key, oct_shift, mute,
    input  buzzer, note_valid, note_idx
  );

  modport slave (
    input  key, oct_shift, mute,
    output buzzer, note_valid, note_idx
  );
endinterface

// File: rtl/poly_key_tone_player_tone_divider.sv
// Square-wave divider: phase toggles each time the counter reaches limit-1.
// Latency: toggle lands on the edge where counter >= limit-1; clear/disable act on the next edge.
// Backpressure: none. Ports: clk, rst, en (run, else phase/counter zeroed), clr (restart half-period, phase kept), limit, phase.
module tone_divider #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             phase
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
    end else if (cnt >= limit - CNT_W'(1)) begin
      // >= rather than ==: a limit that shrinks mid-note below the running
      // count must still produce a toggle instead of wrapping the counter.
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/poly_key_tone_player.sv
// Keyboard-to-tone engine: picks one held key, plays its square wave, keeps a timed release tail.
// Latency: a key level change takes effect on the first edge that samples it.
// Backpressure: none. Ports: clk, rst, bus (slave: key, oct_shift, mute in; buzzer, note_valid, note_idx out).
module poly_key_tone_player
  import tone_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int NUM_KEYS    = 12,
  parameter int CHROMATIC   = 0,
  parameter int PRIORITY    = 0,
  parameter int RELEASE_CYC = 5_000_000,
  parameter int CNT_W       = 20
) (
  input logic                   clk,
  input logic                   rst,
  poly_key_tone_player_if.slave bus
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int TAB_N = 1 << IDX_W;
  localparam int REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [REL_W-1:0] REL_LOAD = REL_W'((RELEASE_CYC > 0) ? RELEASE_CYC - 1 : 0);

  // Per-key octave-4 half-period and octave number, built at elaboration so
  // the runtime pitch path is just a table lookup and a right shift.
  function automatic logic [TAB_N*CNT_W-1:0] build_base();
    logic [TAB_N*CNT_W-1:0] t;
    t = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      t[k*CNT_W +: CNT_W] = CNT_W'(base_half(CLK_HZ, semitone_of(k, CHROMATIC)));
    return t;
  endfunction

  function automatic logic [TAB_N*3-1:0] build_oct();
    logic [TAB_N*3-1:0] t;
    t = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      t[k*3 +: 3] = 3'(semitone_of(k, CHROMATIC) / 12);
    return t;
  endfunction

  localparam logic [TAB_N*CNT_W-1:0] BASE_TAB = build_base();
  localparam logic [TAB_N*3-1:0]     OCT_TAB  = build_oct();

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  state_t              state, state_nx;
  logic [NUM_KEYS-1:0] key_r;
  logic [IDX_W-1:0]    note_idx, idx_nx, sel_idx;
  logic [REL_W-1:0]    rel_cnt, rel_nx;
  logic [NUM_KEYS-1:0] rise;
  logic                any_held;
  logic [CNT_W-1:0]    base_sel, limit;
  logic [3:0]          shift_sum;
  logic [2:0]          shift;
  logic                div_en, div_clr, phase;

  // Note selection from the live key levels; rise compares against last edge.
  always_comb begin
    rise     = bus.key & ~key_r;
    any_held = |bus.key;
    sel_idx  = note_idx;
    if (PRIORITY != 0)
      sel_idx = lowest_set(bus.key);
    else if (|rise)
      sel_idx = lowest_set(rise);
    else if (!bus.key[note_idx])
      // sounding key let go while others remain: fall back to lowest held
      sel_idx = lowest_set(bus.key);
  end

  always_comb begin
    state_nx = state;
    idx_nx   = note_idx;
    rel_nx   = rel_cnt;
    case (state)
      IDLE: begin
        if (any_held) begin
          state_nx = PLAY;
          idx_nx   = sel_idx;
        end
      end
      PLAY: begin
        if (any_held) begin
          idx_nx = sel_idx;
        end else if (RELEASE_CYC == 0) begin
          state_nx = IDLE;
        end else begin
          state_nx = RELEASE;
          rel_nx   = REL_LOAD;
        end
      end
      RELEASE: begin
        if (any_held) begin
          state_nx = PLAY;
          idx_nx   = sel_idx;
        end else if (rel_cnt == '0) begin
          state_nx = IDLE;
        end else begin
          rel_nx = rel_cnt - REL_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      key_r    <= '0;
      note_idx <= '0;
      rel_cnt  <= '0;
    end else begin
      state    <= state_nx;
      key_r    <= bus.key;
      note_idx <= idx_nx;
      rel_cnt  <= rel_nx;
    end
  end

  // Pitch: octave-4 half-period shifted right by key octave plus global shift.
  always_comb begin
    base_sel  = BASE_TAB[int'(note_idx)*CNT_W +: CNT_W];
    shift_sum = {1'b0, OCT_TAB[int'(note_idx)*3 +: 3]} + {2'b00, bus.oct_shift};
    shift     = shift_sum[3] ? 3'd7 : shift_sum[2:0];
    limit     = base_sel >> shift;
    if (limit == '0) limit = CNT_W'(1);
  end

  // Enable follows the next state so the phase is zeroed on the very edge
  // that drops into IDLE; entry from IDLE and note changes restart the count.
  assign div_en  = (state_nx != IDLE);
  assign div_clr = (state == IDLE) || (idx_nx != note_idx);

  tone_divider #(.CNT_W(CNT_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .en    (div_en),
    .clr   (div_clr),
    .limit (limit),
    .phase (phase)
  );

  assign bus.buzzer     = phase & ~bus.mute;
  assign bus.note_valid = (state != IDLE);
  assign bus.note_idx   = note_idx;

endmodule
